mem_access_unit: RTL

Parametrised multi-cycle memory-access stage for the MIPS pipeline, placed between the EX/MEM and MEM/WB registers. It captures one request per handshake and performs byte, halfword or word loads and stores at any legal byte offset, sign- or zero-extending loads. A configurable memory latency is modelled with a wait counter, and the unit raises a busy signal so the pipeline stalls. Misaligned accesses are trapped, and non-memory results pass through in one cycle.

---
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM stage: captures one request per handshake, models a fixed
// memory latency with a down-counter, performs byte/half/word loads and stores
// at any legal byte offset, traps misaligned or reserved-size accesses, and
// forwards non-memory results in a single cycle.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic                     i_mem_read,
  input  logic                     i_mem_write,
  input  logic [1:0]               i_size,
  input  logic                     i_is_unsigned,
  input  logic [ADDR_WIDTH-1:0]    i_addr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_debug_pointer,
  output logic [DATA_WIDTH-1:0]    o_debug_read,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_addr_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Align the addressed lane down to bit 0, keep the access size and extend.
  // Word accesses always arrive with off = 0, so the shifted word is the word.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            off,
    input logic [1:0]            size,
    input logic                  uns
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: load_extend = {{(DATA_WIDTH-8){sh[7] & ~uns}}, sh[7:0]};
      SZ_HALF: load_extend = {{(DATA_WIDTH-16){sh[15] & ~uns}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  // Replicate store data across lanes so lane 'off' holds it, then merge only
  // the enabled byte lanes into the old word.
  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [1:0]            off,
    input logic [1:0]            size
  );
    logic [3:0]            lanes;
    logic [DATA_WIDTH-1:0] rep;
    logic [DATA_WIDTH-1:0] mask;
    case (size)
      SZ_BYTE: begin
        lanes = 4'b0001 << off;
        rep   = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        lanes = 4'b0011 << off;
        rep   = {2{wdata[15:0]}};
      end
      default: begin
        lanes = 4'b1111;
        rep   = wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{lanes[i]}};
    end
    store_merge = (old & ~mask) | (rep & mask);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  wr_p0;
  logic [1:0]            size_p0;
  logic                  uns_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic                  err_p0;

  logic                  is_mem;
  logic                  err_in;
  logic                  accept;
  logic                  do_access;
  logic                  do_write;
  logic [IDX_W-1:0]      idx_p0;
  logic [1:0]            off_p0;
  logic [DATA_WIDTH-1:0] rd_word;

  assign is_mem  = i_mem_read | i_mem_write;
  assign err_in  = is_mem & ((i_size == SZ_RSVD) ||
                             ((i_size == SZ_HALF) && i_addr[0]) ||
                             ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00)));
  assign accept  = (state_q == IDLE) & i_valid;

  // Upper address bits are dropped here, so word indices wrap modulo DEPTH.
  assign idx_p0   = addr_p0[2 +: IDX_W];
  assign off_p0   = addr_p0[1:0];
  assign rd_word  = mem[idx_p0];
  assign do_write = do_access & wr_p0;

  // Stage p0: request capture, loaded only on an accepted handshake
  always_ff @(posedge i_clock) begin
    if (accept) begin
      wr_p0    <= i_mem_write;
      size_p0  <= i_size;
      uns_p0   <= i_is_unsigned;
      addr_p0  <= i_addr;
      wdata_p0 <= i_wdata;
      err_p0   <= err_in;
    end
  end

  // Control state, latency counter and the held result register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state, counter and result selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (!is_mem) begin
            state_d = RESP;
            data_d  = DATA_WIDTH'(i_addr);
          end else if (err_in) begin
            state_d = RESP;
            data_d  = '0;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = RESP;
          data_d    = wr_p0 ? DATA_WIDTH'(addr_p0)
                            : load_extend(rd_word, off_p0, size_p0, uns_p0);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Array write on the final ACCESS edge; a reset drops the FSM to IDLE first
  always_ff @(posedge i_clock) begin
    if (do_write) begin
      mem[idx_p0] <= store_merge(rd_word, wdata_p0, off_p0, size_p0);
    end
  end

  assign o_debug_read = mem[i_debug_pointer];
  assign o_busy       = (state_q != IDLE);
  assign o_valid      = (state_q == RESP);
  assign o_addr_err   = (state_q == RESP) & err_p0;
  assign o_data       = data_q;

endmodule
